// File: rtl/dblbuf_seq_pkg.sv
// Shared types for the ping-pong buffer sequencer.
// Provides the read-state enum and a saturating counter helper used by the optional statistics.
package dblbuf_seq_pkg;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_RUN   = 2'd1,
    R_DRAIN = 2'd2
  } rstate_e;

  localparam int STAT_W = 32;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/dblbuf_seq_rd.sv
// Read-side sequencer: walks the closed tile, keeps one word in flight toward the consumer,
// and flags the final word of the tile.
module dblbuf_seq_rd
  import dblbuf_seq_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH:0]   i_len,
  input  logic                  i_out_ready,
  output logic                  o_idle,
  output logic                  o_r_en_n,
  output logic [ADDR_WIDTH-1:0] o_r_addr,
  output logic                  o_out_valid,
  output logic                  o_out_last
);

  typedef logic [ADDR_WIDTH:0] len_t;

  rstate_e r_state;
  len_t    r_len;
  len_t    r_cnt;
  logic    r_rd_pend;
  logic    r_last_pend;

  logic w_issue;
  logic w_hs;
  logic w_is_final;

  // A new read may only replace the held word once the consumer has taken it.
  assign w_issue    = (r_state == R_RUN) && (!r_rd_pend || i_out_ready);
  assign w_hs       = r_rd_pend && i_out_ready;
  assign w_is_final = (r_cnt == r_len - 1'b1);

  assign o_idle      = (r_state == R_IDLE);
  assign o_r_en_n    = !w_issue;
  assign o_r_addr    = r_cnt[ADDR_WIDTH-1:0];
  assign o_out_valid = r_rd_pend;
  assign o_out_last  = r_rd_pend && r_last_pend;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= R_IDLE;
      r_len       <= '0;
      r_cnt       <= '0;
      r_rd_pend   <= 1'b0;
      r_last_pend <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (i_start) begin
            r_len   <= i_len;
            r_cnt   <= '0;
            r_state <= R_RUN;
          end
        end
        R_RUN: begin
          if (w_issue && w_is_final) r_state <= R_DRAIN;
        end
        R_DRAIN: begin
          if (w_hs) r_state <= R_IDLE;
        end
        default: r_state <= R_IDLE;
      endcase

      if (w_issue) begin
        r_cnt       <= r_cnt + 1'b1;
        r_rd_pend   <= 1'b1;
        r_last_pend <= w_is_final;
      end else if (w_hs) begin
        r_rd_pend   <= 1'b0;
        r_last_pend <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dblbuf_seq.sv
// Ping-pong buffer sequencer top: write-side tile assembly and swap decision; read side in dblbuf_seq_rd.
// Optional tile/stall counters are enabled by defining DBLBUF_SEQ_STATS_EN.
module dblbuf_seq
  import dblbuf_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 2**ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  swap_n,
  output logic                  w_en_n,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic                  r_en_n,
  output logic [ADDR_WIDTH-1:0] r_addr,
`ifdef DBLBUF_SEQ_STATS_EN
  output logic [STAT_W-1:0]     stat_tiles,
  output logic [STAT_W-1:0]     stat_stall,
`endif
  input  logic [DATA_WIDTH-1:0] r_data
);

  typedef logic [ADDR_WIDTH:0] len_t;

  localparam logic [ADDR_WIDTH-1:0] LP_LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  logic [ADDR_WIDTH-1:0] r_w_cnt;
  logic                  r_w_full;
  len_t                  r_w_len;

  logic w_fire;
  logic w_close;
  logic w_swap;
  logic w_rd_idle;

  assign in_ready = !r_w_full;
  assign w_fire   = in_valid && in_ready;
  assign w_close  = w_fire && (in_last || (r_w_cnt == LP_LAST_IDX));
  assign w_swap   = r_w_full && w_rd_idle;

  assign w_en_n   = !w_fire;
  assign w_addr   = r_w_cnt;
  assign w_data   = in_data;
  assign swap_n   = !w_swap;
  assign out_data = r_data;

  // Writes are blocked while full, so closing a tile and swapping never coincide.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_w_cnt  <= '0;
      r_w_full <= 1'b0;
      r_w_len  <= '0;
    end else begin
      if (w_close) begin
        r_w_full <= 1'b1;
        r_w_len  <= {1'b0, r_w_cnt} + 1'b1;
        r_w_cnt  <= '0;
      end else if (w_fire) begin
        r_w_cnt  <= r_w_cnt + 1'b1;
      end
      if (w_swap) r_w_full <= 1'b0;
    end
  end

  dblbuf_seq_rd #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_rd (
    .clock       (clock),
    .reset_n     (reset_n),
    .i_start     (w_swap),
    .i_len       (r_w_len),
    .i_out_ready (out_ready),
    .o_idle      (w_rd_idle),
    .o_r_en_n    (r_en_n),
    .o_r_addr    (r_addr),
    .o_out_valid (out_valid),
    .o_out_last  (out_last)
  );

`ifdef DBLBUF_SEQ_STATS_EN
  logic [STAT_W-1:0] r_stat_tiles;
  logic [STAT_W-1:0] r_stat_stall;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_stat_tiles <= '0;
      r_stat_stall <= '0;
    end else begin
      if (w_swap)                r_stat_tiles <= sat_inc(r_stat_tiles);
      if (in_valid && !in_ready) r_stat_stall <= sat_inc(r_stat_stall);
    end
  end

  assign stat_tiles = r_stat_tiles;
  assign stat_stall = r_stat_stall;
`endif

endmodule

// File: tb/tb_dblbuf_seq.sv
// Directed bench for dblbuf_seq (DEPTH=8) with a two-bank controller stub; define
// DBLBUF_SEQ_STATS_EN to also check the tile counter.
module tb_dblbuf_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready, out_valid, out_last, swap_n, w_en_n, r_en_n;
  logic [15:0] out_data, w_data, r_data;
  logic [2:0]  w_addr, r_addr;
`ifdef DBLBUF_SEQ_STATS_EN
  logic [31:0] stat_tiles, stat_stall;
`endif

  always #5 clk = ~clk;

  dblbuf_seq #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .DEPTH(8)) dut (
    .clock(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .swap_n(swap_n), .w_en_n(w_en_n), .w_addr(w_addr), .w_data(w_data),
    .r_en_n(r_en_n), .r_addr(r_addr),
`ifdef DBLBUF_SEQ_STATS_EN
    .stat_tiles(stat_tiles), .stat_stall(stat_stall),
`endif
    .r_data(r_data)
  );

  // Controller stub: writer owns bank sel, reader owns the other; swap flips them.
  logic [15:0] mem [0:1][0:7];
  logic        sel;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel    <= 1'b0;
      r_data <= '0;
    end else begin
      if (!w_en_n) mem[sel][w_addr] <= w_data;
      if (!r_en_n) r_data <= mem[~sel][r_addr];
      if (!swap_n) sel <= ~sel;
    end
  end

  int n_chk = 0, n_pass = 0;
  int cyc = 0, n_swap = 0, swap_cyc = -1, first_v = -1;
  logic cons_rdy = 1'b1;
  logic [16:0] prod_q[$];
  logic [16:0] got_q[$];
  logic [2:0]  wa_q[$];
  logic [2:0]  ra_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic clear_logs();
    got_q.delete(); wa_q.delete(); ra_q.delete();
    n_swap = 0; swap_cyc = -1; first_v = -1;
  endtask

  task automatic push_word(input logic [15:0] d, input logic l);
    prod_q.push_back({l, d});
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (prod_q.size() > 0) begin
      in_valid = 1'b1; in_data = prod_q[0][15:0]; in_last = prod_q[0][16];
    end else begin
      in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    end
    out_ready = cons_rdy;
    #1;
    if (in_valid && in_ready) begin
      wa_q.push_back(w_addr);
      void'(prod_q.pop_front());
    end
    if (!swap_n) begin n_swap++; swap_cyc = cyc; end
    if (!r_en_n) ra_q.push_back(r_addr);
    if (out_valid && first_v < 0) first_v = cyc;
    if (out_valid && out_ready) begin
      got_q.push_back({out_last, out_data});
      $display("[%0d] out data=%h last=%0b", cyc, out_data, out_last);
    end
  endtask

  task automatic run_until(input int n, input int budget);
    for (int i = 0; i < budget && got_q.size() < n; i++) step();
    chk("nwords", got_q.size(), n);
  endtask

  function automatic logic [31:0] qw(input logic [16:0] q[$], input int i);
    return (i < q.size()) ? {15'd0, q[i]} : 32'hdead_beef;
  endfunction

  function automatic logic [31:0] qa(input logic [2:0] q[$], input int i);
    return (i < q.size()) ? {29'd0, q[i]} : 32'hdead_beef;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_swap_n"}, swap_n, 1);
    chk({tag, "_w_en_n"}, w_en_n, 1);
    chk({tag, "_r_en_n"}, r_en_n, 1);
    chk({tag, "_w_addr"}, w_addr, 0);
    chk({tag, "_r_addr"}, r_addr, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
`ifdef DBLBUF_SEQ_STATS_EN
    chk({tag, "_stat_tiles"}, stat_tiles, 0);
`endif
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    reset_n = 1'b0;
    prod_q.delete();
    clear_logs();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  logic [16:0] exp4 [12];

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk_reset_outputs("rst");
    @(negedge clk);
    reset_n = 1'b1;

    // Single 5-word tile
    clear_logs();
    for (int i = 0; i < 5; i++) push_word(16'h0010 + 16'(i), i == 4);
    run_until(5, 60);
    chk("t1_nswap", n_swap, 1);
    chk("t1_latency", first_v - swap_cyc, 2);
    for (int i = 0; i < 5; i++) begin
      chk("t1_waddr", qa(wa_q, i), i);
      chk("t1_raddr", qa(ra_q, i), i);
      chk("t1_word", qw(got_q, i), {(i == 4), 16'h0010 + 16'(i)});
    end

    // Two auto-closed 8-word tiles
    clear_logs();
    for (int i = 0; i < 16; i++) push_word(16'h0020 + 16'(i), 1'b0);
    run_until(16, 120);
    chk("t2_nswap", n_swap, 2);
    for (int i = 0; i < 16; i++) begin
      chk("t2_waddr", qa(wa_q, i), i % 8);
      chk("t2_word", qw(got_q, i), {(i == 7 || i == 15), 16'h0020 + 16'(i)});
    end

    // Consumer backpressure with the producer blocked behind a full tile
    clear_logs();
    for (int i = 0; i < 6; i++) push_word(16'h0060 + 16'(i), i == 5);
    for (int i = 0; i < 4; i++) push_word(16'h0070 + 16'(i), i == 3);
    for (int i = 0; i < 2; i++) push_word(16'h0080 + 16'(i), i == 1);
    for (int i = 0; i < 60 && got_q.size() < 2; i++) step();
    chk("t3_pre", got_q.size(), 2);
    cons_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_stall_r_en_n", r_en_n, 1);
      chk("t3_stall_valid", out_valid, 1);
      chk("t3_stall_data", out_data, 16'h0062);
    end
    chk("t3_in_valid", in_valid, 1);
    chk("t3_in_ready", in_ready, 0);
    cons_rdy = 1'b1;
    run_until(12, 120);
    for (int i = 0; i < 6; i++) exp4[i] = {(i == 5), 16'h0060 + 16'(i)};
    for (int i = 0; i < 4; i++) exp4[6 + i] = {(i == 3), 16'h0070 + 16'(i)};
    for (int i = 0; i < 2; i++) exp4[10 + i] = {(i == 1), 16'h0080 + 16'(i)};
    for (int i = 0; i < 12; i++) chk("t3_word", qw(got_q, i), {15'd0, exp4[i]});
    chk("t3_nswap", n_swap, 3);

    // Ten back-to-back single-word tiles from a fresh reset
    pulse_reset();
    for (int i = 0; i < 10; i++) push_word(16'h0040 + 16'(i), 1'b1);
    run_until(10, 150);
    chk("t4_nswap", n_swap, 10);
    for (int i = 0; i < 10; i++) chk("t4_word", qw(got_q, i), {1'b1, 16'h0040 + 16'(i)});
`ifdef DBLBUF_SEQ_STATS_EN
    step();
    chk("t4_stat_tiles", stat_tiles, 10);
`endif

    // Reset while the reader is running
    clear_logs();
    for (int i = 0; i < 6; i++) push_word(16'h0090 + 16'(i), i == 5);
    run_until(1, 60);
    in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    prod_q.delete();
    clear_logs();
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) push_word(16'h00a0 + 16'(i), i == 2);
    run_until(3, 60);
    chk("t5_nswap", n_swap, 1);
    for (int i = 0; i < 3; i++) begin
      chk("t5_waddr", qa(wa_q, i), i);
      chk("t5_raddr", qa(ra_q, i), i);
      chk("t5_word", qw(got_q, i), {(i == 2), 16'h00a0 + 16'(i)});
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dblbuf_seq.md
Name: dblbuf_seq

Overview:
- Sequencer for the ping-pong buffer controller: turns a producer valid/ready stream into write-port commands and a consumer valid/ready stream from read-port commands.
- Decides when to pulse swap_n. Sits between the producer/consumer pipeline stages and the double-buffer controller, which drives the two SRAM banks.
- Tiles are variable length, 1..DEPTH words, closed by in_last or by reaching DEPTH.

Parameters:
- DATA_WIDTH, 16, word width
- ADDR_WIDTH, 8, buffer address width
- DEPTH, 2**ADDR_WIDTH, maximum words per tile (2..2**ADDR_WIDTH)

Ports:
- clock  in  1  single clock
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  producer word valid
- in_ready  out  1  producer may transfer
- in_data  in  DATA_WIDTH  producer word
- in_last  in  1  word closes current tile
- out_valid  out  1  consumer word valid
- out_ready  in  1  consumer accepts
- out_data  out  DATA_WIDTH  consumer word (= r_data)
- out_last  out  1  final word of tile
- swap_n  out  1  to controller, active-low one-cycle swap pulse
- w_en_n  out  1  to controller write enable, active low
- w_addr  out  ADDR_WIDTH  write address
- w_data  out  DATA_WIDTH  write data (= in_data)
- r_en_n  out  1  to controller read enable, active low
- r_addr  out  ADDR_WIDTH  read address
- r_data  in  DATA_WIDTH  read data, valid cycle after r_en_n=0, held until next read

Behaviour:
- Reset (async, reset_n=0): w_cnt=0, w_full=0, r_len=0, r_cnt=0, rstate=R_IDLE, rd_pend=0.
  - Outputs during and after reset: swap_n=1, w_en_n=1, r_en_n=1, w_addr=0, r_addr=0, out_valid=0, out_last=0, in_ready=1.
  - The controller shares reset_n, so its bank select returns to bank 0 coherently. Reset mid-tile discards both banks.
- Write side:
  - in_ready = !w_full.
  - On in_valid&&in_ready: w_en_n=0, w_addr=w_cnt and w_cnt++, all combinational in the same cycle.
  - If in_last or w_cnt==DEPTH-1: w_full<=1 and w_len<=w_cnt+1 (ADDR_WIDTH+1 bits), then w_cnt<=0.
- Swap:
  - swap_n=0 (combinational) when w_full && rstate==R_IDLE.
  - Next edge: w_full<=0, r_len<=w_len, r_cnt<=0, rstate<=R_RUN.
  - No write or read command is issued in the swap cycle.
- Read FSM:
  - R_IDLE: no reads; out_valid=0.
  - R_RUN: issue read (r_en_n=0, r_addr=r_cnt, r_cnt++) when !rd_pend || out_ready. rd_pend<=1 on issue; rd_pend<=0 on handshake without a new issue. After issuing index r_len-1 go to R_DRAIN.
  - R_DRAIN: no new reads. On handshake of the final word go to R_IDLE.
  - out_valid = rd_pend. out_last = rd_pend && (the pending word's index == r_len-1), tracked by a registered flag.
- Latency:
  - Swap at cycle T; first r_en_n=0 at T+1; out_valid at T+2.
  - With out_ready held high, sustained throughput is 1 word/cycle. Each tile costs one swap cycle plus one read-drain bubble.
- Backpressure: if out_ready=0 while rd_pend, no read is issued, so r_data stays stable. out_data and out_last hold until the handshake.
- Concurrency: the write tile fills while the read tile drains.
  - If the producer finishes first, in_ready stays 0 until the swap.
  - If the consumer finishes first, the FSM idles until w_full.
- Boundaries:
  - Tile length 1 (in_last on the first word) is legal: r_len=1 goes straight to R_DRAIN after one read.
  - DEPTH words without in_last auto-close the tile; w_addr wraps to 0 for the next tile.
  - in_last together with w_cnt==DEPTH-1 closes the tile once.

Optional Feature:
- Macro DBLBUF_SEQ_STATS_EN.
- When defined, adds outputs:
  - stat_tiles (32-bit): increments once per swap.
  - stat_stall (32-bit): increments each cycle in_valid && !in_ready.
  - Both counters reset to 0 and saturate at all-ones.
- When undefined, these ports and registers are absent; all other behaviour is identical.

Decomposition:
- Package dblbuf_seq_pkg holds:
  - rstate_e enum {R_IDLE, R_RUN, R_DRAIN}.
  - Length type len_t, ADDR_WIDTH+1 bits, parameterised via a function or local typedef in the module.
- One sub-module is natural: dblbuf_seq_rd, containing the read FSM, r_cnt, rd_pend and out_last generation. The write side and swap logic stay in the top.

Test Plan:
- Single tile: words 0..4 with in_last on word 4, out_ready=1.
  - Expect w_addr 0..4, then one swap_n pulse, then r_addr 0..4.
  - out_data 0..4, out_last on 4, first out_valid 2 cycles after the swap.
- DEPTH=8, 8 words with no in_last: auto-close, swap. A second tile of 8 words writes at w_addr 0..7 while tile 1 drains; no data loss.
- Consumer backpressure: out_ready=0 for 5 cycles mid-tile.
  - r_en_n stays 1; out_data is stable.
  - Producer stalls (in_ready=0) once the next tile is full; resumes after the drain and swap.
- Length-1 tiles back-to-back, 10 tiles:
  - Each tile yields one swap and one out word with out_last=1.
  - With DBLBUF_SEQ_STATS_EN defined, stat_tiles=10.
- Reset mid-read (reset_n low for 1 cycle during R_RUN):
  - All outputs return to reset values immediately; out_valid=0.
  - A new tile of 3 words is then delivered correctly from bank 0.
